// File: rtl/prefix_sum_engine.sv
// Prefix-sum engine: scans a_mem into b_mem (inclusive or exclusive) and reports the grand total.
// Optional saturating accumulation with a sticky overflow flag when PREFIX_SUM_SAT_EN is defined.
module prefix_sum_engine #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   n,
  input  logic              exclusive,
  input  logic              a_wr_en,
  input  logic [ADDR_W-1:0] a_wr_addr,
  input  logic [DATA_W-1:0] a_wr_data,
  input  logic [ADDR_W-1:0] b_rd_addr,
  output logic [DATA_W-1:0] b_rd_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] return_val
`ifdef PREFIX_SUM_SAT_EN
  ,
  output logic              overflow
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ACCUM  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0] a_mem [DEPTH];
  logic [DATA_W-1:0] b_mem [DEPTH];

  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [ADDR_W:0]   idx_reg, idx_next;
  logic [ADDR_W:0]   n_eff_reg, n_eff_next;
  logic              excl_reg, excl_next;
  logic [DATA_W-1:0] return_val_reg, return_val_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [DATA_W-1:0] b_rd_data_reg;

  logic [DATA_W-1:0] a_rd_data_reg;
  logic [ADDR_W:0]   n_clamped;
  logic [DATA_W-1:0] sum_val;
  logic              b_wr_en;
  logic [DATA_W-1:0] b_wr_data;
  logic              a_wr_ok;
  logic              a_rd_en;

`ifdef PREFIX_SUM_SAT_EN
  logic [DATA_W:0]   sum_wide;
  logic              sum_sat;
  logic              overflow_reg, overflow_next;

  assign sum_wide = {1'b0, acc_reg} + {1'b0, a_rd_data_reg};
  assign sum_sat  = sum_wide[DATA_W];
  assign sum_val  = sum_sat ? {DATA_W{1'b1}} : sum_wide[DATA_W-1:0];
`else
  assign sum_val  = acc_reg + a_rd_data_reg;
`endif

  assign n_clamped = (n > DEPTH_C) ? DEPTH_C : n;
  assign b_wr_data = excl_reg ? acc_reg : sum_val;
  // Host writes only land while the engine is idle so a run sees a stable input array.
  assign a_wr_ok   = a_wr_en && (state_reg == IDLE);
  assign a_rd_en   = (state_reg == FETCH);

  // Next-state and datapath decode
  always_comb begin
    state_next      = state_reg;
    acc_next        = acc_reg;
    idx_next        = idx_reg;
    n_eff_next      = n_eff_reg;
    excl_next       = excl_reg;
    return_val_next = return_val_reg;
    b_wr_en         = 1'b0;
`ifdef PREFIX_SUM_SAT_EN
    overflow_next   = overflow_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          n_eff_next = n_clamped;
          excl_next  = exclusive;
          acc_next   = '0;
          idx_next   = '0;
`ifdef PREFIX_SUM_SAT_EN
          overflow_next = 1'b0;
`endif
          state_next = (n_clamped == '0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        state_next = ACCUM;
      end
      ACCUM: begin
        b_wr_en  = 1'b1;
        acc_next = sum_val;
        idx_next = idx_reg + ONE_C;
`ifdef PREFIX_SUM_SAT_EN
        if (sum_sat) begin
          overflow_next = 1'b1;
        end
`endif
        state_next = ((idx_reg + ONE_C) == n_eff_reg) ? FINISH : FETCH;
      end
      FINISH: begin
        return_val_next = acc_reg;
        state_next      = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_reg == FINISH);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg      <= IDLE;
      acc_reg        <= '0;
      idx_reg        <= '0;
      n_eff_reg      <= '0;
      excl_reg       <= 1'b0;
      return_val_reg <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
`ifdef PREFIX_SUM_SAT_EN
      overflow_reg   <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      idx_reg        <= idx_next;
      n_eff_reg      <= n_eff_next;
      excl_reg       <= excl_next;
      return_val_reg <= return_val_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
`ifdef PREFIX_SUM_SAT_EN
      overflow_reg   <= overflow_next;
`endif
    end
  end

  // Memory arrays carry no reset so they map onto block RAM.
  always_ff @(posedge sys_clk) begin
    if (a_wr_ok) begin
      a_mem[a_wr_addr] <= a_wr_data;
    end
    if (a_rd_en) begin
      a_rd_data_reg <= a_mem[idx_reg[ADDR_W-1:0]];
    end
    if (b_wr_en) begin
      b_mem[idx_reg[ADDR_W-1:0]] <= b_wr_data;
    end
  end

  // Read-first port: a same-cycle write to this address is seen one cycle later.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      b_rd_data_reg <= '0;
    end else begin
      b_rd_data_reg <= b_mem[b_rd_addr];
    end
  end

  assign b_rd_data  = b_rd_data_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign return_val = return_val_reg;
`ifdef PREFIX_SUM_SAT_EN
  assign overflow   = overflow_reg;
`endif

endmodule
